// File: rtl/aim_uart_tx.sv
// Serialises one tracker result per frame into a 7-byte UART 8N1 packet:
// sync, flags, x_hi, x_lo, y_hi, y_lo, XOR checksum (each byte LSB first).
module aim_uart_tx #(
  parameter int         CLK_HZ    = 25_000_000,
  parameter int         BAUD      = 115200,
  parameter logic [7:0] SYNC_BYTE = 8'hAA
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_stb,
  input  logic [9:0] aim_x,
  input  logic [9:0] aim_y,
  input  logic       aim_detected,
  input  logic       raser_shoot,
  input  logic       target_off,
  output logic       tx,
  output logic       busy,
  output logic       frame_dropped
);

  localparam int BAUD_DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_reg, bit_next;
  logic [2:0]       byte_reg, byte_next;
  logic [7:0]       shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic             drop_reg, drop_next;
  logic [2:0]       flags_reg, flags_next;
  logic [9:0]       x_reg, x_next;
  logic [9:0]       y_reg, y_next;

  // Packet image built from the snapshot; entry 7 is a pad so a 3-bit index is always in range.
  logic [7:0] pkt [8];
  assign pkt[0] = SYNC_BYTE;
  assign pkt[1] = {5'b0, flags_reg};
  assign pkt[2] = {6'b0, x_reg[9:8]};
  assign pkt[3] = x_reg[7:0];
  assign pkt[4] = {6'b0, y_reg[9:8]};
  assign pkt[5] = y_reg[7:0];
  assign pkt[6] = pkt[1] ^ pkt[2] ^ pkt[3] ^ pkt[4] ^ pkt[5];
  assign pkt[7] = 8'h00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      byte_reg  <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
      drop_reg  <= 1'b0;
      flags_reg <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      byte_reg  <= byte_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      drop_reg  <= drop_next;
      flags_reg <= flags_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
    end
  end

  always_comb begin
    logic bit_end;
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    byte_next  = byte_reg;
    shift_next = shift_reg;
    flags_next = flags_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    drop_next  = frame_stb && (state_reg != IDLE);
    bit_end    = (cnt_reg == CNT_LAST);

    if (state_reg != IDLE) begin
      cnt_next = bit_end ? '0 : cnt_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (frame_stb) begin
          state_next = START;
          cnt_next   = '0;
          bit_next   = '0;
          byte_next  = '0;
          shift_next = pkt[0];
          flags_next = {target_off, raser_shoot, aim_detected};
          x_next     = aim_x;
          y_next     = aim_y;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_reg == 3'd6) begin
            state_next = IDLE;
          end else begin
            // Next start bit follows the stop bit with no idle gap.
            state_next = START;
            byte_next  = byte_reg + 3'd1;
            shift_next = pkt[byte_reg + 3'd1];
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is registered from the next state so tx is glitch-free.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign tx            = tx_reg;
  assign busy          = (state_reg != IDLE);
  assign frame_dropped = drop_reg;

endmodule

// File: tb/tb_aim_uart_tx.sv
// Directed bench for aim_uart_tx: decodes the line cycle by cycle against
// hand-computed packets, and checks drop, snapshot and mid-packet reset.
module tb_aim_uart_tx;

  localparam int DIV  = 217;
  localparam int BYTE = 10 * DIV;
  localparam int PKT  = 7 * BYTE;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_stb = 1'b0;
  logic [9:0] aim_x = '0;
  logic [9:0] aim_y = '0;
  logic       aim_detected = 1'b0;
  logic       raser_shoot = 1'b0;
  logic       target_off = 1'b0;
  logic       tx;
  logic       busy;
  logic       frame_dropped;

  int n_cmp = 0;
  int n_fail = 0;

  aim_uart_tx dut (
    .clk          (clk),
    .reset        (reset),
    .frame_stb    (frame_stb),
    .aim_x        (aim_x),
    .aim_y        (aim_y),
    .aim_detected (aim_detected),
    .raser_shoot  (raser_shoot),
    .target_off   (target_off),
    .tx           (tx),
    .busy         (busy),
    .frame_dropped(frame_dropped)
  );

  always #5 clk = ~clk;

  // Called at a negedge; strobes, then checks every line cycle of the packet.
  task automatic run_packet(input string name, input logic [9:0] x, input logic [9:0] y,
                            input logic d, input logic s, input logic o,
                            input logic [6:0][7:0] exp, input int drop_at,
                            input int abort_at, input bit chg);
    logic [7:0] got;
    logic       exp_bit;
    int         line_err, busy_err, drop_err;
    int         k, c, bn, b;
    got = '0; line_err = 0; busy_err = 0; drop_err = 0;
    aim_x = x; aim_y = y; aim_detected = d; raser_shoot = s; target_off = o;
    frame_stb = 1'b1;
    @(negedge clk);
    frame_stb = 1'b0;
    for (int i = 0; i < PKT; i++) begin
      k = i / DIV; c = i % DIV; bn = k / 10; b = k % 10;
      if (b == 0) exp_bit = 1'b0;
      else if (b == 9) exp_bit = 1'b1;
      else exp_bit = exp[bn][b-1];
      if (tx !== exp_bit) line_err++;
      if (busy !== 1'b1) busy_err++;
      if (frame_dropped !== (i == drop_at + 1)) drop_err++;
      if (c == DIV / 2 && b >= 1 && b <= 8) got[b-1] = tx;
      if (i % BYTE == BYTE - 1) begin
        n_cmp++;
        if (got !== exp[bn]) begin
          n_fail++;
          $display("FAIL %s byte%0d: got %h expected %h", name, bn, got, exp[bn]);
        end
        n_cmp++;
        if (line_err !== 0) begin
          n_fail++;
          $display("FAIL %s byte%0d timing: %0d bad line cycles, expected 0", name, bn, line_err);
        end
        $display("%s byte%0d: got %h expected %h", name, bn, got, exp[bn]);
        line_err = 0;
      end
      if (chg && (i % 100 == 50)) begin
        aim_x = 10'($urandom); aim_y = 10'($urandom);
        aim_detected = ~aim_detected; raser_shoot = ~raser_shoot; target_off = ~target_off;
      end
      if (i == drop_at) frame_stb = 1'b1;
      if (i == drop_at + 1) frame_stb = 1'b0;
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL %s abort: tx=%b busy=%b expected tx=1 busy=0", name, tx, busy);
        end
        $display("%s abort at cycle %0d: tx=%b busy=%b", name, i, tx, busy);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (busy_err !== 0 || drop_err !== 0) begin
      n_fail++;
      $display("FAIL %s flags: busy_err=%0d drop_err=%0d expected 0/0", name, busy_err, drop_err);
    end
    n_cmp++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL %s end: busy=%b tx=%b expected busy=0 tx=1", name, busy, tx);
    end
  endtask

  task automatic idle_check(input string name, input int cycles);
    int err;
    err = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || frame_dropped !== 1'b0) err++;
    end
    n_cmp++;
    if (err !== 0) begin
      n_fail++;
      $display("FAIL %s idle: %0d bad cycles, expected 0", name, err);
    end
    $display("%s idle %0d cycles: bad=%0d", name, cycles, err);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++;
    if (frame_dropped !== 1'b0) begin
      n_fail++; $display("FAIL reset_drop: got %b expected 0", frame_dropped);
    end
    $display("reset: tx=%b busy=%b frame_dropped=%b", tx, busy, frame_dropped);
    reset = 1'b0;
    idle_check("reset", 1000);
  endtask

  task automatic test_basic();
    run_packet("pkt320_240", 10'd320, 10'd240, 1'b1, 1'b1, 1'b0,
               56'hB2_F0_00_40_01_03_AA, -100, -1, 1'b0);
    idle_check("pkt320_240", 20);
    run_packet("pkt1023_0", 10'd1023, 10'd0, 1'b0, 1'b0, 1'b1,
               56'hF8_00_00_FF_03_04_AA, -100, -1, 1'b0);
    idle_check("pkt1023_0", 20);
  endtask

  task automatic test_snapshot();
    run_packet("snapshot", 10'h2A5, 10'h15A, 1'b1, 1'b0, 1'b1,
               56'hF9_5A_01_A5_02_05_AA, -100, -1, 1'b1);
    idle_check("snapshot", 20);
  endtask

  task automatic test_drop();
    run_packet("drop", 10'd320, 10'd240, 1'b1, 1'b1, 1'b0,
               56'hB2_F0_00_40_01_03_AA, 5000, -1, 1'b0);
    idle_check("drop", 300);
  endtask

  task automatic test_back_to_back();
    run_packet("b2b_first", 10'd1023, 10'd0, 1'b0, 1'b0, 1'b1,
               56'hF8_00_00_FF_03_04_AA, -100, -1, 1'b0);
    run_packet("b2b_second", 10'd320, 10'd240, 1'b1, 1'b1, 1'b0,
               56'hB2_F0_00_40_01_03_AA, -100, -1, 1'b0);
    idle_check("b2b", 20);
  endtask

  task automatic test_reset_mid();
    run_packet("rst_mid", 10'd320, 10'd240, 1'b1, 1'b1, 1'b0,
               56'hB2_F0_00_40_01_03_AA, -100, 3 * BYTE + 5 * DIV + 100, 1'b0);
    idle_check("rst_mid", 10);
    run_packet("after_rst", 10'h2A5, 10'h15A, 1'b1, 1'b0, 1'b1,
               56'hF9_5A_01_A5_02_05_AA, -100, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_snapshot();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
